// File: rtl/spi_slave.sv
// SPI responder for the boot link: oversamples SS/SCK/MOSI in the system clock domain,
// samples MOSI on SCK rise, drives MISO on SCK fall and reports each complete frame.
module spi_slave #(
  parameter int FRAME_W     = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic               spi_clk_i,
  input  logic               spi_rst_i,
  input  logic               spi_fbo_i,
  input  logic [FRAME_W-1:0] transmission_data_i,
  input  logic               SS,
  input  logic               SCK,
  input  logic               MOSI,
  output logic               MISO,
  output logic               miso_oe_o,
  output logic               busy_o,
  output logic               done,
  output logic               frame_err_o,
  output logic [FRAME_W-1:0] received_data_o
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_DONE, S_WAIT_SS, S_ABORT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
  logic                   ss_d, sck_d;
  logic                   ss_s, sck_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;
  logic                   last_rise, ss_gone_q;

  logic               fbo_q;
  logic [FRAME_W-1:0] tx_sh, rx_sh;
  logic [CNT_W-1:0]   bit_cnt;

  // SS history resets low so an SS already low at reset release never looks like a fall.
  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      ss_sync   <= '0;
      ss_d      <= 1'b0;
      sck_sync  <= '1;
      sck_d     <= 1'b1;
      mosi_sync <= '1;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_d      <= ss_s;
      sck_d     <= sck_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign last_rise = sck_rise && (bit_cnt == LAST_BIT);

  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (ss_fall) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        // A final bit arriving with SS rise completes the frame rather than aborting it.
        if (last_rise)    state_nxt = S_DONE;
        else if (ss_rise) state_nxt = S_ABORT;
      end
      S_DONE:    state_nxt = (ss_gone_q || ss_rise) ? S_IDLE : S_WAIT_SS;
      S_WAIT_SS: if (ss_rise) state_nxt = S_IDLE;
      S_ABORT:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      fbo_q           <= 1'b1;
      tx_sh           <= '1;
      rx_sh           <= '1;
      bit_cnt         <= '0;
      ss_gone_q       <= 1'b0;
      received_data_o <= '1;
    end else begin
      ss_gone_q <= (state == S_ACTIVE) && last_rise && ss_rise;
      if (state == S_IDLE && ss_fall) begin
        fbo_q   <= spi_fbo_i;
        tx_sh   <= transmission_data_i;
        rx_sh   <= '1;
        bit_cnt <= '0;
      end else if (state == S_ACTIVE) begin
        if (sck_rise) begin
          rx_sh   <= fbo_q ? {rx_sh[FRAME_W-2:0], mosi_s} : {mosi_s, rx_sh[FRAME_W-1:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (sck_fall && bit_cnt != '0)
          tx_sh <= fbo_q ? {tx_sh[FRAME_W-2:0], 1'b1} : {1'b1, tx_sh[FRAME_W-1:1]};
      end
      if (state == S_DONE) received_data_o <= rx_sh;
    end
  end

  always_comb begin
    MISO        = 1'b1;
    miso_oe_o   = 1'b0;
    busy_o      = 1'b0;
    done        = 1'b0;
    frame_err_o = 1'b0;
    unique case (state)
      S_ACTIVE: begin
        MISO      = fbo_q ? tx_sh[FRAME_W-1] : tx_sh[0];
        miso_oe_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_DONE: begin
        miso_oe_o = 1'b1;
        busy_o    = 1'b1;
        done      = 1'b1;
      end
      S_WAIT_SS: begin
        miso_oe_o = 1'b1;
        busy_o    = 1'b1;
      end
      S_ABORT: begin
        busy_o      = 1'b1;
        frame_err_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master drives table-driven, hand-written and random
// frames; expectations come from word-level rules (what was sent, what was latched).
module tb_spi_slave;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fbo = 1'b1;
  logic [47:0] txd = '0;
  logic        SS = 1'b1, SCK = 1'b1, MOSI = 1'b1;
  logic        MISO, miso_oe, busy, done, ferr;
  logic [47:0] rxd;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  spi_slave #(.FRAME_W(48), .SYNC_STAGES(2)) dut (
    .spi_clk_i(clk), .spi_rst_i(rst_n), .spi_fbo_i(fbo),
    .transmission_data_i(txd), .SS(SS), .SCK(SCK), .MOSI(MOSI),
    .MISO(MISO), .miso_oe_o(miso_oe), .busy_o(busy), .done(done),
    .frame_err_o(ferr), .received_data_o(rxd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (ferr === 1'b1) err_cnt++;
  end

  typedef struct {
    logic        fbo;
    logic [47:0] mw;
    logic [47:0] tx;
    int          n;
    logic [47:0] exp_rx;
    int          exp_done;
    int          exp_err;
    logic        chk_cap;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Master side: n SCK cycles, MOSI set on the fall, MISO captured just before the rise.
  task automatic xfer(input logic [47:0] mw, input logic f, input logic [47:0] tx, input int n,
                      input logic ss_with_last, input int gap,
                      output logic [47:0] cap, output logic extra_ones);
    cap = '1;
    extra_ones = 1'b1;
    fbo = f;
    txd = tx;
    SS = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      int b;
      b = f ? 47 - i : i;
      SCK = 1'b0;
      MOSI = (i < 48) ? mw[b] : 1'($urandom);
      repeat (HALF) @(negedge clk);
      if (i < 48) cap[b] = MISO;
      else if (MISO !== 1'b1) extra_ones = 1'b0;
      SCK = 1'b1;
      if (ss_with_last && i == n - 1) SS = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    SS = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic f, input logic [47:0] mw,
                           input logic [47:0] tx, input int n, input logic sslast,
                           input logic [47:0] exp_rx, input int exp_done, input int exp_err,
                           input logic chk_cap);
    int d0, e0;
    logic [47:0] cap;
    logic xo;
    d0 = done_cnt;
    e0 = err_cnt;
    xfer(mw, f, tx, n, sslast, 8, cap, xo);
    check({tag, ".rx"}, rxd, exp_rx);
    check({tag, ".done"}, 48'(done_cnt - d0), 48'(exp_done));
    check({tag, ".err"}, 48'(err_cnt - e0), 48'(exp_err));
    if (chk_cap) check({tag, ".miso_word"}, cap, tx);
    if (n > 48) check({tag, ".tail_ones"}, 48'(xo), 48'd1);
    check({tag, ".idle"}, {45'd0, busy, miso_oe, MISO}, 48'b001);
  endtask

  initial begin
    logic [47:0] model_rx;
    logic [47:0] cap;
    logic        xo;
    int          d0;

    vecs[0] = '{1'b1, 48'hA5A5_0F0F_1234, 48'h0123_4567_89AB, 48, 48'hA5A5_0F0F_1234, 1, 0, 1'b1};
    vecs[1] = '{1'b0, 48'hA5A5_0F0F_1234, 48'h0123_4567_89AB, 48, 48'hA5A5_0F0F_1234, 1, 0, 1'b1};
    vecs[2] = '{1'b1, 48'h0F1E_2D3C_4B5A, 48'hFEDC_BA98_7654, 60, 48'h0F1E_2D3C_4B5A, 1, 0, 1'b1};
    vecs[3] = '{1'b1, 48'h1111_1111_1111, 48'h0000_0000_0000, 20, 48'h0F1E_2D3C_4B5A, 0, 1, 1'b0};
    vecs[4] = '{1'b0, 48'h8000_0000_0001, 48'h7FFF_FFFF_FFFE, 48, 48'h8000_0000_0001, 1, 0, 1'b1};

    repeat (3) @(negedge clk);
    check("reset.flags", {44'd0, MISO, miso_oe, busy, done | ferr}, 48'b1000);
    check("reset.rx", rxd, '1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].fbo, vecs[i].mw, vecs[i].tx, vecs[i].n, 1'b0,
                vecs[i].exp_rx, vecs[i].exp_done, vecs[i].exp_err, vecs[i].chk_cap);

    // Back-to-back frames, 4 idle clocks apart, each returning its own latched word.
    d0 = done_cnt;
    xfer(48'h1234_5678_9ABC, 1'b1, 48'hCAFE_F00D_BEEF, 48, 1'b0, 4, cap, xo);
    check("b2b.cap1", cap, 48'hCAFE_F00D_BEEF);
    check("b2b.rx1", rxd, 48'h1234_5678_9ABC);
    xfer(48'h0BAD_C0DE_7777, 1'b1, 48'h5555_AAAA_3C3C, 48, 1'b0, 8, cap, xo);
    check("b2b.cap2", cap, 48'h5555_AAAA_3C3C);
    check("b2b.rx2", rxd, 48'h0BAD_C0DE_7777);
    check("b2b.done", 48'(done_cnt - d0), 48'd2);

    // SS rising together with the 48th SCK rise still completes the frame.
    run_frame("ss_last", 1'b0, 48'hDEAD_BEEF_0042, 48'h1357_9BDF_2468, 48, 1'b1,
              48'hDEAD_BEEF_0042, 1, 0, 1'b1);

    model_rx = 48'hDEAD_BEEF_0042;
    for (int i = 0; i < 10; i++) begin
      logic        rf;
      logic [47:0] rmw, rtx;
      int          rn;
      rf  = 1'($urandom);
      rmw = 48'({$urandom, $urandom});
      rtx = 48'({$urandom, $urandom});
      rn  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 47) : 48;
      if (rn == 48) model_rx = rmw;
      run_frame($sformatf("rand%0d", i), rf, rmw, rtx, rn, 1'b0, model_rx,
                (rn == 48) ? 1 : 0, (rn == 48) ? 0 : 1, rn == 48);
    end

    // Reset mid-frame, with SS still low when reset releases.
    fbo = 1'b1;
    txd = 48'h0000_FFFF_0000;
    SS = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      SCK = 1'b0; repeat (HALF) @(negedge clk);
      SCK = 1'b1; repeat (HALF) @(negedge clk);
    end
    SCK = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst.flags", {44'd0, MISO, miso_oe, busy, done | ferr}, 48'b1000);
    check("midrst.rx", rxd, '1);
    SCK = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("ss_low_at_release.busy", 48'(busy), 48'd0);
    SS = 1'b1;
    repeat (8) @(negedge clk);
    run_frame("post_rst", 1'b1, 48'h6789_ABCD_EF01, 48'h2222_4444_8888, 48, 1'b0,
              48'h6789_ABCD_EF01, 1, 0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

48-bit SPI responder for the FPGA side of the boot link: it is the far end of the team's 48-bit SPI master. It oversamples SS/SCK/MOSI in the system clock domain. Receive data is shifted in on SCK rising edges, and transmit data is driven onto MISO on SCK falling edges (SCK idles high). A completed frame is handed to fabric logic as a one-cycle valid pulse. Bit order is selectable per frame.

## Interface
- FRAME_W, 48, bits per frame; counter and shift registers are sized from it.
- SYNC_STAGES, 2, synchronizer depth on SS, SCK and MOSI; must be at least 2.
- spi_clk_i  input  1  system clock; all logic is on its rising edge.
- spi_rst_i  input  1  reset; asynchronous, active-low.
- spi_fbo_i  input  1  first-bit-out select; 1 = MSB first, 0 = LSB first; sampled at frame start.
- transmission_data_i  input  48  word returned to the master; latched at frame start.
- SS  input  1  slave select, active low, asynchronous to spi_clk_i.
- SCK  input  1  serial clock, idles high, asynchronous.
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master; 1 whenever not active.
- miso_oe_o  output  1  MISO output enable; 1 while the frame is active.
- busy_o  output  1  1 from frame start until DONE or ABORT is exited.
- done  output  1  one-cycle pulse: a full frame was received.
- frame_err_o  output  1  one-cycle pulse: SS rose before FRAME_W bits were sampled.
- received_data_o  output  48  last complete frame; holds its value until the next complete frame.

## Operation
- Reset values: MISO=1, miso_oe_o=0, busy_o=0, done=0, frame_err_o=0, received_data_o=48'hFFFFFFFFFFFF.
- Reset also sets the shift registers to all ones, the bit counter to 0 and the state to IDLE.
- Synchronizers: SS_s, SCK_s and MOSI_s are SYNC_STAGES flops each.
- Edge detect: one extra register per synchronized signal. It produces sck_rise, sck_fall, ss_fall and ss_rise as single-cycle strobes.
- IDLE:
  - On ss_fall, go to ACTIVE.
  - On the same cycle: latch spi_fbo_i into fbo_q, load tx_sh with transmission_data_i, clear bit_cnt, set rx_sh to all ones.
  - Drive MISO = fbo_q ? tx_sh[47] : tx_sh[0] from the next cycle.
- ACTIVE, on sck_rise:
  - If bit_cnt < FRAME_W: shift MOSI_s into rx_sh and increment bit_cnt.
  - fbo_q=1: rx_sh = {rx_sh[46:0], MOSI_s}.
  - fbo_q=0: rx_sh = {MOSI_s, rx_sh[47:1]}.
  - When bit_cnt reaches FRAME_W, go to DONE.
- ACTIVE, on sck_fall:
  - The first falling edge of a frame (bit_cnt == 0) does not shift; the first bit is already on MISO.
  - Later falling edges shift tx_sh one place toward the output end with 1-fill, and MISO follows.
- ACTIVE, on ss_rise with bit_cnt < FRAME_W: go to ABORT.
- DONE: for one cycle, received_data_o <= rx_sh and done=1. Then go to WAIT_SS.
- WAIT_SS:
  - SCK edges are ignored; MISO=1 and miso_oe_o stays 1.
  - On ss_rise, go to IDLE.
- ABORT: for one cycle frame_err_o=1. received_data_o is not changed. Go to IDLE.
- Simultaneous events:
  - ss_rise in the same cycle as the 48th sck_rise: the bit is taken, the frame completes, and the FSM goes DONE then IDLE (WAIT_SS is skipped).
  - sck_fall coincident with ss_fall is ignored.
- If SS is already low when reset releases, the FSM stays in IDLE until a clean ss_fall.

## Timing
- Pin-to-strobe latency is SYNC_STAGES+1 cycles.
- MISO changes SYNC_STAGES+2 cycles after the SCK falling pin edge.
- Requirements on the master:
  - SCK high and low phases are each at least 4 spi_clk_i periods (master divider ≥ 2 with an equal or slower master clock).
  - SS setup to the first SCK fall is at least 4 spi_clk_i periods.
- done asserts 1 cycle after the registered 48th sck_rise, i.e. SYNC_STAGES+2 cycles after the pin edge.
- frame_err_o asserts 1 cycle after ss_rise is registered.
- busy_o rises 1 cycle after ss_fall is registered. It falls on entry to IDLE.
- miso_oe_o is 1 in ACTIVE, DONE and WAIT_SS.

## Test plan
- Reset: hold spi_rst_i low mid-frame → all outputs return to their reset values asynchronously. The next full frame is received correctly.
- MSB first: spi_fbo_i=1, master sends 48'hA5A5_0F0F_1234 while transmission_data_i=48'h0123_4567_89AB → received_data_o=48'hA5A50F0F1234 with one done pulse. The master captures 48'h0123456789AB.
- LSB first: spi_fbo_i=0, same words → identical captured values on both sides. The MISO first bit is 1 (bit 0 of 48'h...89AB).
- Abort: SS raised after 20 bits → one frame_err_o pulse, no done, received_data_o unchanged, busy_o falls, MISO=1.
- Overlong frame: 60 SCK cycles with SS low → done fires once after bit 48. Bits 49-60 on MISO are all 1. received_data_o equals the first 48 bits.
- Back-to-back frames: two frames separated by 4 idle clocks, and transmission_data_i changed between them → each frame returns the value latched at its own SS fall. Two done pulses.
